// File: rtl/mbd_pkg.sv
// Shared types and width helpers for the multi-button detector.
// Imported by the channel and top modules.
package mbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_N_BTN        = 5;
  localparam int DEF_TICK_DIV     = 500000;
  localparam int DEF_DEB_SAMPLES  = 3;
  localparam int DEF_HOLD_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, tick-paced debounce and the
// idle/pressed/held state machine with auto-repeat.
module button_channel
  import mbd_pkg::*;
#(
  parameter int DEB_SAMPLES   = DEF_DEB_SAMPLES,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter bit ACTIVE_LOW_IN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic held
);

  localparam int DW = cnt_w(DEB_SAMPLES);
  localparam int HW = cnt_w(HOLD_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          deb_hit;
  logic          hold_hit;
  logic          rep_hit;
  logic          press_nxt;
  logic          rel_nxt;
  state_t        state;
  state_t        state_nxt;

  // Two-FF synchroniser, runs every clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ ACTIVE_LOW_IN;

  // Final differing sample: level flips on this edge
  assign deb_hit = tick && (s != level)
                   && (deb_cnt == DEB_LAST);

  assign hold_hit = tick && (hold_cnt == HOLD_LAST);

  assign rep_hit = tick && repeat_en
                   && (rep_cnt == REP_LAST);

  // Debounce counter and accepted level
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (tick) begin
      if (s == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: a level change beats hold/repeat
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (deb_hit) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (deb_hit)       state_nxt = IDLE;
        else if (hold_hit) state_nxt = HELD;
      end
      HELD: begin
        if (deb_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: held flag and next pulse values
  always_comb begin
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    held      = 1'b0;
    unique case (state)
      IDLE: begin
        press_nxt = deb_hit;
      end
      PRESSED: begin
        if (deb_hit)       rel_nxt   = 1'b1;
        else if (hold_hit) press_nxt = repeat_en;
      end
      HELD: begin
        held = 1'b1;
        if (deb_hit)      rel_nxt   = 1'b1;
        else if (rep_hit) press_nxt = 1'b1;
      end
      default: begin
        press_nxt = 1'b0;
      end
    endcase
  end

  // Register the pulses alongside level and state
  always_ff @(posedge clk) begin
    if (!rst) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= press_nxt;
      release_pulse <= rel_nxt;
    end
  end

  // Hold and repeat counters, advanced on tick only
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (tick) begin
      unique case (state)
        PRESSED: begin
          rep_cnt <= '0;
          if (deb_hit || hold_cnt == HOLD_LAST)
            hold_cnt <= '0;
          else
            hold_cnt <= hold_cnt + HW'(1);
        end
        HELD: begin
          hold_cnt <= '0;
          if (deb_hit || !repeat_en
              || rep_cnt == REP_LAST)
            rep_cnt <= '0;
          else
            rep_cnt <= rep_cnt + RW'(1);
        end
        default: begin
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_button_detector.sv
// N-channel button front end: one shared sample tick
// feeding an independent channel per button.
module multi_button_detector
  import mbd_pkg::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int DEB_SAMPLES   = DEF_DEB_SAMPLES,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter bit ACTIVE_LOW_IN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] held
);

  localparam int TW = cnt_w(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // With TICK_DIV=1 the counter sits at 0 and tick stays high
  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample-tick divider
  always_ff @(posedge clk) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEB_SAMPLES   (DEB_SAMPLES),
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS),
      .ACTIVE_LOW_IN (ACTIVE_LOW_IN)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .btn           (btn_in[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .held          (held[i])
    );
  end

endmodule
